// File: rtl/npu_requant.sv
// Requantises a signed accumulator stream to int8: multiply, round-half-up shift,
// zero-point add, optional ReLU and saturation, behind a two-stage skid-free pipeline.
module npu_requant #(
  parameter int IN_WIDTH           = 16,
  parameter int OUT_WIDTH          = 8,
  parameter int MULT_WIDTH         = 16,
  parameter int SHIFT_WIDTH        = 5,
  parameter int NUM_CHANNELS_WIDTH = 7,
  parameter int SAT_CNT_WIDTH      = 16
) (
  input  logic                          s00_axis_aclk,
  input  logic                          s00_axis_areset,
  input  logic signed [IN_WIDTH-1:0]    s00_axis_tdata,
  input  logic                          s00_axis_tvalid,
  input  logic                          s00_axis_tlast,
  input  logic [NUM_CHANNELS_WIDTH-1:0] s00_axis_tuser,
  output logic                          s00_axis_tready,
  output logic signed [OUT_WIDTH-1:0]   m00_axis_tdata,
  output logic                          m00_axis_tvalid,
  output logic                          m00_axis_tlast,
  output logic [NUM_CHANNELS_WIDTH-1:0] m00_axis_tuser,
  input  logic                          m00_axis_tready,
  input  logic signed [MULT_WIDTH-1:0]  cfg_mult,
  input  logic [SHIFT_WIDTH-1:0]        cfg_shift,
  input  logic signed [OUT_WIDTH-1:0]   cfg_zero_point,
  input  logic                          cfg_relu,
  output logic [SAT_CNT_WIDTH-1:0]      sat_count
);

  localparam int PW = IN_WIDTH + MULT_WIDTH;
  localparam int RW = PW + 2;
  localparam logic signed [RW-1:0] OUT_MAX = RW'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [RW-1:0] OUT_MIN = -OUT_MAX - RW'(1);

  // Two guard bits keep the rounding constant and zero-point add from overflowing.
  function automatic logic signed [RW-1:0] round_shift(input logic signed [PW-1:0] p,
                                                      input logic [SHIFT_WIDTH-1:0] sh);
    logic signed [RW-1:0] ext;
    logic signed [RW-1:0] half;
    ext  = {{2{p[PW-1]}}, p};
    half = {{(RW-1){1'b0}}, 1'b1} << (sh - SHIFT_WIDTH'(1));
    return (sh == '0) ? ext : ((ext + half) >>> sh);
  endfunction

  function automatic logic is_sat(input logic signed [RW-1:0] v);
    return (v > OUT_MAX) || (v < OUT_MIN);
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] clamp_out(input logic signed [RW-1:0] v,
                                                           input logic signed [OUT_WIDTH-1:0] zp,
                                                           input logic relu);
    logic signed [RW-1:0] lo;
    logic signed [RW-1:0] res;
    lo = relu ? {{(RW-OUT_WIDTH){zp[OUT_WIDTH-1]}}, zp} : OUT_MIN;
    if (v > OUT_MAX)  res = OUT_MAX;
    else if (v < lo)  res = lo;
    else              res = v;
    return res[OUT_WIDTH-1:0];
  endfunction

  logic                          in_frame_q, in_frame_d;
  logic signed [MULT_WIDTH-1:0]  mult_lat_q, mult_lat_d;
  logic [SHIFT_WIDTH-1:0]        shift_lat_q, shift_lat_d;
  logic signed [OUT_WIDTH-1:0]   zp_lat_q, zp_lat_d;
  logic                          relu_lat_q, relu_lat_d;

  logic                          vld_p1_q, vld_p1_d;
  logic signed [PW-1:0]          prod_p1_q, prod_p1_d;
  logic [SHIFT_WIDTH-1:0]        shift_p1_q, shift_p1_d;
  logic signed [OUT_WIDTH-1:0]   zp_p1_q, zp_p1_d;
  logic                          relu_p1_q, relu_p1_d;
  logic                          last_p1_q, last_p1_d;
  logic [NUM_CHANNELS_WIDTH-1:0] user_p1_q, user_p1_d;
  logic                          first_p1_q, first_p1_d;

  logic                          vld_p2_q, vld_p2_d;
  logic signed [OUT_WIDTH-1:0]   data_p2_q, data_p2_d;
  logic                          last_p2_q, last_p2_d;
  logic [NUM_CHANNELS_WIDTH-1:0] user_p2_q, user_p2_d;
  logic [SAT_CNT_WIDTH-1:0]      sat_count_q, sat_count_d;

  logic                          load_p1, load_p2, accept;
  logic signed [MULT_WIDTH-1:0]  mult_eff;
  logic signed [RW-1:0]          v_p1;
  logic                          sat_p1;

  assign load_p2         = !vld_p2_q || m00_axis_tready;
  assign load_p1         = !vld_p1_q || load_p2;
  assign s00_axis_tready = !vld_p1_q || !vld_p2_q || m00_axis_tready;
  assign accept          = s00_axis_tvalid && s00_axis_tready;
  assign mult_eff        = in_frame_q ? mult_lat_q : cfg_mult;

  assign v_p1   = round_shift(prod_p1_q, shift_p1_q) + {{(RW-OUT_WIDTH){zp_p1_q[OUT_WIDTH-1]}}, zp_p1_q};
  assign sat_p1 = is_sat(v_p1);

  always_comb begin
    in_frame_d  = in_frame_q;
    mult_lat_d  = mult_lat_q;
    shift_lat_d = shift_lat_q;
    zp_lat_d    = zp_lat_q;
    relu_lat_d  = relu_lat_q;
    vld_p1_d    = vld_p1_q;
    prod_p1_d   = prod_p1_q;
    shift_p1_d  = shift_p1_q;
    zp_p1_d     = zp_p1_q;
    relu_p1_d   = relu_p1_q;
    last_p1_d   = last_p1_q;
    user_p1_d   = user_p1_q;
    first_p1_d  = first_p1_q;
    vld_p2_d    = vld_p2_q;
    data_p2_d   = data_p2_q;
    last_p2_d   = last_p2_q;
    user_p2_d   = user_p2_q;
    sat_count_d = sat_count_q;

    if (accept) begin
      in_frame_d = !s00_axis_tlast;
      if (!in_frame_q) begin
        mult_lat_d  = cfg_mult;
        shift_lat_d = cfg_shift;
        zp_lat_d    = cfg_zero_point;
        relu_lat_d  = cfg_relu;
      end
    end

    // S1: multiply; per-beat shift/zp/relu ride along so frames can differ back-to-back
    if (load_p1) begin
      vld_p1_d = accept;
      if (accept) begin
        prod_p1_d  = s00_axis_tdata * mult_eff;
        shift_p1_d = in_frame_q ? shift_lat_q : cfg_shift;
        zp_p1_d    = in_frame_q ? zp_lat_q : cfg_zero_point;
        relu_p1_d  = in_frame_q ? relu_lat_q : cfg_relu;
        last_p1_d  = s00_axis_tlast;
        user_p1_d  = s00_axis_tuser;
        first_p1_d = !in_frame_q;
      end
    end

    // S2: round, offset, clamp; drives the output stream
    if (load_p2) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        data_p2_d = clamp_out(v_p1, zp_p1_q, relu_p1_q);
        last_p2_d = last_p1_q;
        user_p2_d = user_p1_q;
        if (first_p1_q)
          sat_count_d = SAT_CNT_WIDTH'(sat_p1);
        else if (sat_p1 && (sat_count_q != '1))
          sat_count_d = sat_count_q + SAT_CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      in_frame_q  <= 1'b0;
      mult_lat_q  <= '0;
      shift_lat_q <= '0;
      zp_lat_q    <= '0;
      relu_lat_q  <= 1'b0;
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      data_p2_q   <= '0;
      last_p2_q   <= 1'b0;
      user_p2_q   <= '0;
      sat_count_q <= '0;
    end else begin
      in_frame_q  <= in_frame_d;
      mult_lat_q  <= mult_lat_d;
      shift_lat_q <= shift_lat_d;
      zp_lat_q    <= zp_lat_d;
      relu_lat_q  <= relu_lat_d;
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      data_p2_q   <= data_p2_d;
      last_p2_q   <= last_p2_d;
      user_p2_q   <= user_p2_d;
      sat_count_q <= sat_count_d;
    end
  end

  always_ff @(posedge s00_axis_aclk) begin
    prod_p1_q  <= prod_p1_d;
    shift_p1_q <= shift_p1_d;
    zp_p1_q    <= zp_p1_d;
    relu_p1_q  <= relu_p1_d;
    last_p1_q  <= last_p1_d;
    user_p1_q  <= user_p1_d;
    first_p1_q <= first_p1_d;
  end

  assign m00_axis_tvalid = vld_p2_q;
  assign m00_axis_tdata  = data_p2_q;
  assign m00_axis_tlast  = last_p2_q;
  assign m00_axis_tuser  = user_p2_q;
  assign sat_count       = sat_count_q;

endmodule

// File: tb/tb_npu_requant.sv
// Scoreboard bench for npu_requant: a reference model predicts every accepted beat,
// the monitor process pops and compares each emitted beat.
module tb_npu_requant;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic signed [15:0] s_tdata;
  logic              s_tvalid, s_tlast, s_tready;
  logic [6:0]        s_tuser;
  logic signed [7:0] m_tdata;
  logic              m_tvalid, m_tlast, m_tready;
  logic [6:0]        m_tuser;
  logic signed [15:0] cfg_mult;
  logic [4:0]        cfg_shift;
  logic signed [7:0] cfg_zp;
  logic              cfg_relu;
  logic [15:0]       sat_count;

  npu_requant dut (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .s00_axis_tdata  (s_tdata),
    .s00_axis_tvalid (s_tvalid),
    .s00_axis_tlast  (s_tlast),
    .s00_axis_tuser  (s_tuser),
    .s00_axis_tready (s_tready),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tlast  (m_tlast),
    .m00_axis_tuser  (m_tuser),
    .m00_axis_tready (m_tready),
    .cfg_mult        (cfg_mult),
    .cfg_shift       (cfg_shift),
    .cfg_zero_point  (cfg_zp),
    .cfg_relu        (cfg_relu),
    .sat_count       (sat_count)
  );

  typedef struct packed {
    logic [7:0]  data;
    logic        last;
    logic [6:0]  user;
    logic [15:0] sat;
  } exp_t;

  typedef struct packed {
    logic [7:0] data;
    logic [6:0] user;
  } log_t;

  int   errors = 0;
  int   checks = 0;
  int   acc_count = 0;
  int   out_count = 0;
  exp_t sb[$];
  log_t out_log[$];

  bit               in_frame_m;
  logic signed [15:0] mult_m;
  logic [4:0]       shift_m;
  logic signed [7:0] zp_m;
  logic             relu_m;
  int               fsat_m;

  // Returns {saturated, int8 result}
  function automatic logic [8:0] model_beat(input int d, input int mult, input int shift,
                                            input int zp, input bit relu);
    longint p, r, v, lo, o;
    p = longint'(d) * longint'(mult);
    if (shift == 0) r = p;
    else            r = (p + (longint'(1) <<< (shift - 1))) >>> shift;
    v  = r + longint'(zp);
    lo = relu ? longint'(zp) : -128;
    if (v > 127)     o = 127;
    else if (v < lo) o = lo;
    else             o = v;
    return {((v > 127) || (v < -128)), o[7:0]};
  endfunction

  initial begin : monitor
    exp_t       e;
    exp_t       got;
    logic [8:0] res;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        in_frame_m = 1'b0;
        fsat_m = 0;
      end else begin
        if (m_tvalid && m_tready) begin
          out_count++;
          out_log.push_back({m_tdata, m_tuser});
          got = {m_tdata, m_tlast, m_tuser, sat_count};
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL out_unexpected: data=%0d user=%0d emitted but no beat expected", m_tdata, m_tuser);
          end else begin
            e = sb.pop_front();
            if (got !== e) begin
              errors++;
              $display("FAIL out_beat: got data=%0d last=%0b user=%0d sat=%0d, expected data=%0d last=%0b user=%0d sat=%0d",
                       $signed(got.data), got.last, got.user, got.sat,
                       $signed(e.data), e.last, e.user, e.sat);
            end
          end
        end
        if (s_tvalid && s_tready) begin
          acc_count++;
          if (!in_frame_m) begin
            mult_m  = cfg_mult;
            shift_m = cfg_shift;
            zp_m    = cfg_zp;
            relu_m  = cfg_relu;
            fsat_m  = 0;
          end
          res = model_beat(int'(s_tdata), int'(mult_m), int'(shift_m), int'(zp_m), relu_m);
          if (res[8] && fsat_m < 65535) fsat_m++;
          sb.push_back({res[7:0], s_tlast, s_tuser, 16'(fsat_m)});
          in_frame_m = !s_tlast;
        end
      end
    end
  end

  task automatic drive_beat(input int d, input bit last, input int user);
    bit ok;
    ok = 1'b0;
    s_tdata  = 16'(d);
    s_tlast  = last;
    s_tuser  = 7'(user);
    s_tvalid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (s_tready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: beat %0d not accepted, ready=%0b required 1", d, s_tready);
    end
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && !m_tvalid) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain_timeout: %0d beats still outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({m_tvalid, m_tlast, m_tuser, m_tdata} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%0b last=%0b user=%0d data=%0d, required all 0", m_tvalid, m_tlast, m_tuser, m_tdata);
    end
    checks++;
    if (sat_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_sat: sat_count=%0d, required 0", sat_count);
    end
    checks++;
    if (s_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_tready: s_tready=%0b, required 1", s_tready);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: s_tready=%0b m_tvalid=%0b, required 1 and 0", s_tready, m_tvalid);
    end
  endtask

  task automatic test_basic();
    logic signed [7:0] exp_b [4] = '{8'sd47, -8'sd6, -8'sd128, 8'sd127};
    out_log.delete();
    cfg_mult = 16'sd16384; cfg_shift = 5'd15; cfg_zp = -8'sd3; cfg_relu = 1'b0;
    m_tready = 1'b1;
    drive_beat(100, 1'b0, 5);
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: m_tvalid=%0b one cycle after accept, required 0", m_tvalid);
    end
    drive_beat(-7, 1'b0, 5);
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 8'sd47) begin
      errors++;
      $display("FAIL latency_first: valid=%0b data=%0d, required 1 and 47", m_tvalid, m_tdata);
    end
    drive_beat(-1000, 1'b0, 5);
    drive_beat(300, 1'b1, 5);
    wait_drain();
    checks++;
    if (out_log.size() != 4) begin
      errors++;
      $display("FAIL basic_count: %0d beats, required 4", out_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (out_log[i].data !== exp_b[i]) begin
          errors++;
          $display("FAIL basic_data%0d: got %0d, required %0d", i, $signed(out_log[i].data), exp_b[i]);
        end
      end
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sat_count !== 16'd2) begin
      errors++;
      $display("FAIL basic_sat: sat_count=%0d after frame, required 2", sat_count);
    end
  endtask

  task automatic test_relu_round();
    int t_mult [9]  = '{16384, 16384, 1, 1, 1, 1, 1, 1, 1};
    int t_shift [9] = '{15, 15, 0, 1, 1, 0, 0, 0, 0};
    int t_zp [9]    = '{0, 0, 0, 0, 0, 10, -128, 127, 127};
    int t_relu [9]  = '{1, 0, 0, 0, 0, 1, 0, 0, 0};
    int t_din [9]   = '{-7, -7, 5, 3, -3, -50, -200, 1, 0};
    int t_exp [9]   = '{0, -3, 5, 2, -1, 10, -128, 127, 127};
    int t_sat [9]   = '{0, 0, 0, 0, 0, 0, 1, 1, 0};
    m_tready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      out_log.delete();
      cfg_mult = 16'(t_mult[i]); cfg_shift = 5'(t_shift[i]);
      cfg_zp = 8'(t_zp[i]); cfg_relu = t_relu[i][0];
      drive_beat(t_din[i], 1'b1, i);
      wait_drain();
      checks++;
      if (out_log.size() != 1 || out_log[0].data !== 8'(t_exp[i]) || sat_count !== 16'(t_sat[i])) begin
        errors++;
        $display("FAIL relu_round%0d: beats=%0d data=%0d sat=%0d, required 1 beat data=%0d sat=%0d",
                 i, out_log.size(), (out_log.size() > 0) ? $signed(out_log[0].data) : 8'sd0,
                 sat_count, t_exp[i], t_sat[i]);
      end
    end
  endtask

  task automatic test_cfg_frames();
    log_t exp_l [4] = '{{8'd10, 7'd3}, {8'd10, 7'd3}, {8'd40, 7'd9}, {8'd40, 7'd9}};
    out_log.delete();
    m_tready = 1'b1;
    cfg_mult = 16'sd2; cfg_shift = 5'd1; cfg_zp = 8'sd0; cfg_relu = 1'b0;
    drive_beat(10, 1'b0, 3);
    cfg_mult = 16'sd4; cfg_shift = 5'd0;
    drive_beat(10, 1'b1, 3);
    drive_beat(10, 1'b0, 9);
    drive_beat(10, 1'b1, 9);
    wait_drain();
    checks++;
    if (out_log.size() != 4) begin
      errors++;
      $display("FAIL cfg_count: %0d beats, required 4", out_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (out_log[i] !== exp_l[i]) begin
          errors++;
          $display("FAIL cfg_beat%0d: data=%0d user=%0d, required data=%0d user=%0d",
                   i, out_log[i].data, out_log[i].user, exp_l[i].data, exp_l[i].user);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int acc0;
    logic signed [7:0] early;
    out_log.delete();
    acc0 = acc_count;
    cfg_mult = 16'sd1; cfg_shift = 5'd0; cfg_zp = 8'sd0; cfg_relu = 1'b0;
    m_tready = 1'b0;
    fork
      begin
        for (int k = 1; k <= 6; k++) drive_beat(k, k == 6, 1);
      end
      begin
        repeat (3) @(posedge clk);
        #1 early = m_tdata;
        checks++;
        if (m_tvalid !== 1'b1 || early !== 8'sd1) begin
          errors++;
          $display("FAIL bp_hold_early: valid=%0b data=%0d, required 1 and 1", m_tvalid, early);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (acc_count - acc0 != 2) begin
          errors++;
          $display("FAIL bp_accepted: %0d beats accepted, required 2", acc_count - acc0);
        end
        checks++;
        if (s_tready !== 1'b0) begin
          errors++;
          $display("FAIL bp_tready: s_tready=%0b, required 0", s_tready);
        end
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== early || m_tdata !== 8'sd1) begin
          errors++;
          $display("FAIL bp_stable: valid=%0b data=%0d, required 1 and 1", m_tvalid, m_tdata);
        end
        m_tready = 1'b1;
      end
    join
    wait_drain();
    checks++;
    if (out_log.size() != 6) begin
      errors++;
      $display("FAIL bp_count: %0d beats emitted, required 6", out_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (out_log[i].data !== 8'(i + 1)) begin
          errors++;
          $display("FAIL bp_order%0d: got %0d, required %0d", i, out_log[i].data, i + 1);
        end
      end
    end
  endtask

  task automatic test_random();
    int sent;
    int acc0, out0;
    bit done;
    sent = 0;
    done = 1'b0;
    acc0 = acc_count;
    out0 = out_count;
    fork
      begin
        while (sent < 1000) begin
          int flen;
          int user;
          flen = $urandom_range(1, 8);
          user = $urandom_range(0, 127);
          for (int k = 0; k < flen && sent < 1000; k++) begin
            cfg_mult  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 4095)) - 2048);
            cfg_shift = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(8, 16));
            cfg_zp    = 8'($urandom);
            cfg_relu  = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) begin
              @(posedge clk); #1;
            end
            if ($urandom_range(0, 1) == 0)
              drive_beat(int'($signed(16'($urandom))), (k == flen - 1) || (sent == 999), user);
            else
              drive_beat(int'($urandom_range(0, 1023)) - 512, (k == flen - 1) || (sent == 999), user);
            sent++;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          m_tready = ($urandom_range(0, 3) != 0);
        end
        m_tready = 1'b1;
      end
    join
    wait_drain();
    checks++;
    if (acc_count - acc0 != 1000 || out_count - out0 != 1000) begin
      errors++;
      $display("FAIL random_count: accepted=%0d emitted=%0d, required 1000 each",
               acc_count - acc0, out_count - out0);
    end
  endtask

  task automatic test_reset_midframe();
    cfg_mult = 16'sd3; cfg_shift = 5'd0; cfg_zp = 8'sd0; cfg_relu = 1'b0;
    m_tready = 1'b0;
    drive_beat(7, 1'b0, 2);
    drive_beat(8, 1'b0, 2);
    checks++;
    if (m_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: m_tvalid=%0b with beats in flight, required 1", m_tvalid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (m_tvalid !== 1'b0 || m_tdata !== 8'sd0 || sat_count !== 16'd0 || s_tready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: valid=%0b data=%0d sat=%0d tready=%0b, required 0 0 0 1",
               m_tvalid, m_tdata, sat_count, s_tready);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    cfg_mult = 16'sd1; cfg_shift = 5'd0; cfg_zp = 8'sd5; cfg_relu = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (m_tvalid !== 1'b0) begin
        errors++;
        $display("FAIL rst_idle%0d: m_tvalid=%0b after reset release, required 0", i, m_tvalid);
      end
    end
    out_log.delete();
    drive_beat(7, 1'b0, 4);
    drive_beat(20, 1'b1, 4);
    wait_drain();
    checks++;
    if (out_log.size() != 2 || out_log[0].data !== 8'sd12 || out_log[1].data !== 8'sd25) begin
      errors++;
      $display("FAIL rst_fresh_cfg: beats=%0d first=%0d second=%0d, required 2 beats 12 and 25",
               out_log.size(), (out_log.size() > 0) ? $signed(out_log[0].data) : 8'sd0,
               (out_log.size() > 1) ? $signed(out_log[1].data) : 8'sd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = '0;
    m_tready = 1'b1;
    cfg_mult = '0; cfg_shift = '0; cfg_zp = '0; cfg_relu = 1'b0;
    test_reset();
    test_basic();
    test_relu_round();
    test_cfg_frames();
    test_backpressure();
    test_random();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
